// File: rtl/rgb_pkg.sv
// Shared types for the RGB sequencer slice: button debouncer FSM states and
// the sequencer's own colour states.
package rgb_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'b00,
      PRESS_WAIT   = 2'b01,
      PRESSED      = 2'b11,
      RELEASE_WAIT = 2'b10
   } button_state_e;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'b00,
      SEQ_RED   = 2'b01,
      SEQ_GREEN = 2'b10,
      SEQ_BLUE  = 2'b11
   } seq_state_e;

   // Flops between an asynchronous pad and the first consumer in clk.
   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pad input; resets to 0.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizes the raw pad, filters contact bounce
// with a stability counter, and emits a debounced level plus press/release pulses.
module button_debouncer
   import rgb_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic button_raw,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2) begin : g_param_check
      $error("button_debouncer: DEBOUNCE_CYCLES must be at least 2");
   end

   button_state_e    state, next_state;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             s;
   logic             done;
   logic             illegal;
   logic             press_next, release_next, pressed_next;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (button_raw),
      .q     (s)
   );

   assign done = (cnt == CNT_LAST);

   always_comb begin
      next_state = state;
      illegal    = 1'b0;
      case (state)
         IDLE:         if (s) next_state = PRESS_WAIT;
         PRESS_WAIT: begin
            if (!s)        next_state = IDLE;
            else if (done) next_state = PRESSED;
         end
         PRESSED:      if (!s) next_state = RELEASE_WAIT;
         RELEASE_WAIT: begin
            if (s)         next_state = PRESSED;
            else if (done) next_state = IDLE;
         end
         default: begin
            next_state = button_state_e'('x);
            illegal    = 1'b1;
         end
      endcase

      press_next   = (state == PRESS_WAIT) && (next_state == PRESSED);
      release_next = (state == RELEASE_WAIT) && (next_state == IDLE);
      pressed_next = (next_state == PRESSED) || (next_state == RELEASE_WAIT);
      if (illegal) begin
         press_next   = 1'bx;
         release_next = 1'bx;
         pressed_next = 1'bx;
      end

      // done always forces an exit, so the counter never reaches wrap-around
      if ((next_state != state) || (state == IDLE) || (state == PRESSED))
         cnt_next = '0;
      else
         cnt_next = cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         pressed       <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= next_state;
         cnt           <= cnt_next;
         pressed       <= pressed_next;
         press_pulse   <= press_next;
         release_pulse <= release_next;
      end
   end

endmodule
